// File: rtl/decode_issue.sv
// Decode/issue stage: accepts one instruction, issues it to an external ALU,
// and writes the registered ALU result back to a local register file.
// The sequence IDLE -> ISSUE -> WB gives one instruction per three cycles.
module decode_issue #(
    parameter int unsigned DW   = 64,
    parameter int unsigned NREG = 32
) (
    input  logic          c,
    input  logic          rst,
    input  logic [31:0]   in_instr,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [7:0]    alu_op,
    output logic          alu_go,
    input  logic [DW-1:0] alu_out,
    output logic          done,
    output logic          err,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

    state_e        state_q, state_d;
    logic [31:0]   instr_q;
    logic [DW-1:0] rf_q [NREG];

    // Fields of the latched instruction
    logic [7:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       imm_sel;
    logic [7:0] imm;

    assign op      = instr_q[31:24];
    assign rd      = instr_q[23:19];
    assign rs1     = instr_q[18:14];
    assign rs2     = instr_q[13:9];
    assign imm_sel = instr_q[8];
    assign imm     = instr_q[7:0];

    logic          legal;
    logic          wr_en;
    logic [DW-1:0] rs1_val, rs2_val, imm_ext;

    // 0x00-0x0F are ALU ops; 0x80 is a noop that retires without writing
    assign legal = (op[7:4] == 4'h0) || (op == 8'h80);

    assign wr_en = (state_q == StWb) && legal && (op != 8'h80) &&
                   (rd != 5'd0) && (32'(rd) < NREG);

    // Register 0 and addresses beyond NREG read as zero
    assign rs1_val  = (rs1 != 5'd0 && 32'(rs1) < NREG) ? rf_q[rs1] : '0;
    assign rs2_val  = (rs2 != 5'd0 && 32'(rs2) < NREG) ? rf_q[rs2] : '0;
    assign dbg_data = (dbg_addr != 5'd0 && 32'(dbg_addr) < NREG) ? rf_q[dbg_addr] : '0;
    assign imm_ext  = {{(DW-8){1'b0}}, imm};

    // State register
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the instruction on an accepted handshake
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (state_q == StIdle && in_valid) begin
            instr_q <= in_instr;
        end
    end

    // Register file; writeback lands at the edge that closes WB, so the next
    // instruction's ISSUE already sees it
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[rd] <= alu_out;
        end
    end

    // Next-state and registered-state-decoded outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        alu_go   = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = '0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                alu_go  = 1'b1;
                alu_op  = op;
                alu_a   = rs1_val;
                alu_b   = imm_sel ? imm_ext : rs2_val;
                state_d = StWb;
            end
            StWb: begin
                done    = 1'b1;
                err     = ~legal;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
